rx_frame_checker: RTL

Parametrised receive-side frame checker and buffer between the RX shift engine and the bus read interface. It sits directly after the RX shift register. On each frame-done strobe it remaps the raw left-justified frame to a right-justified data word for the programmed data length (5..DMAX bits). It then checks parity and the stop bit, and pushes data plus error flags into a show-ahead FIFO with a pop handshake, level count and sticky overrun.

---
 rtl/rx_frame_checker.sv | 139 +++++++++++++
 1 files changed

// File: rtl/rx_frame_checker.sv
// Receive frame checker: remaps a left-justified RX frame, checks parity/stop,
// and buffers {brk, ferr, perr, data} in a show-ahead FIFO. Optional macro: RX_BREAK_DETECT_EN.
module rx_frame_checker #(
  parameter int DMAX  = 8,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [DMAX+1:0]            i_frame,
  input  logic                       i_done,
  input  logic [3:0]                 i_nbits,
  input  logic                       i_pen,
  input  logic                       i_odd,
  input  logic                       i_read,
  input  logic                       i_clr_ovf,
  output logic [DMAX-1:0]            o_data,
  output logic                       o_perr,
  output logic                       o_ferr,
  output logic                       o_brk,
  output logic                       o_valid,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       o_ovf
);

  localparam int FW = DMAX + 2;
  localparam int EW = DMAX + 3;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [3:0]    NMAX  = 4'(DMAX);
  localparam logic [LW-1:0] LFULL = LW'(DEPTH);

  function automatic logic [3:0] clamp_nbits(input logic [3:0] nb);
    if (nb < 4'd5 || nb > NMAX) return NMAX;
    return nb;
  endfunction

  // The stop bit sits at the MSB, so shorter frames sit higher; shift them down by S.
  function automatic logic [EW-1:0] check_frame(input logic [FW-1:0] fr,
                                                input logic [3:0]    nb,
                                                input logic          pen,
                                                input logic          odd);
    logic [4:0]      shamt;
    logic [DMAX-1:0] mask;
    logic [DMAX-1:0] data;
    logic            pbit;
    logic            stop;
    logic            perr;
    logic            ferr;
    logic            brk;
    shamt = 5'(DMAX + 1) - {1'b0, nb} - {4'b0, pen};
    mask  = ~({DMAX{1'b1}} << nb);
    data  = DMAX'(fr >> shamt) & mask;
    pbit  = fr[DMAX];
    stop  = fr[FW-1];
    perr  = pen & ((^data) ^ pbit ^ odd);
    ferr  = ~stop;
`ifdef RX_BREAK_DETECT_EN
    brk   = (data == '0) & ~(pen & pbit) & ~stop;
`else
    brk   = 1'b0;
`endif
    return {brk, ferr, perr, data};
  endfunction

  logic          s1_vld_q, s1_vld_d;
  logic [EW-1:0] s1_ent_q, s1_ent_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] head;
  logic          full;
  logic          empty;
  logic          pop;
  logic          wr_en;
  logic          ovf_set;

  // Stage 1: check register, loaded only on the frame-done strobe.
  always_comb begin
    s1_vld_d = i_done;
    s1_ent_d = s1_ent_q;
    if (i_done) s1_ent_d = check_frame(i_frame, clamp_nbits(i_nbits), i_pen, i_odd);
  end

  // Stage 2: FIFO write; a pop frees the slot in the same cycle a full write needs it.
  always_comb begin
    full     = (level_q == LFULL);
    empty    = (level_q == '0);
    pop      = i_read & ~empty;
    wr_en    = s1_vld_q & (~full | pop);
    ovf_set  = s1_vld_q & full & ~pop;
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q + LW'(wr_en) - LW'(pop);
    ovf_d    = ovf_q;
    if (i_clr_ovf) ovf_d = 1'b0;
    if (ovf_set)   ovf_d = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_vld_q <= 1'b0;
      s1_ent_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_ent_q <= s1_ent_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= s1_ent_q;
  end

  // Show-ahead head, forced to zero when empty so stale storage never leaks out.
  always_comb begin
    head    = mem_q[rd_ptr_q];
    o_valid = ~empty;
    o_level = level_q;
    o_ovf   = ovf_q;
    o_data  = o_valid ? head[DMAX-1:0] : '0;
    o_perr  = o_valid & head[DMAX];
    o_ferr  = o_valid & head[DMAX+1];
`ifdef RX_BREAK_DETECT_EN
    o_brk   = o_valid & head[DMAX+2];
`else
    o_brk   = 1'b0;
`endif
  end

endmodule
